pipelined_shifter: RTL and testbench

- Parametrised, pipelined barrel shifter for the multi-cycle and pipelined CPU datapaths; successor to the single-cycle 32-bit combinational shifter.
- Width is generic. Adds rotate modes and a configurable number of register stages. Uses a valid/ready handshake with backpressure.
- A tag travels with each operation, so the EX stage can match results to destination registers.

---
 rtl/pipelined_shifter_if.sv | 36 +++
 rtl/pipelined_shifter.sv | 180 ++++++++++++++++++
 tb/tb_pipelined_shifter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_shifter_if.sv
// rtl/pipelined_shifter_if.sv - request/result bundle for pipelined_shifter
// Purpose: groups the operand request (in_*) and result (out_*) handshakes.
// Ports (signals):
//   in_valid/in_ready/in_data/in_amt/in_op/in_tag      request handshake and operands
//   out_valid/out_ready/out_data/out_tag               result handshake and payload
//   out_carry/out_zero                                 result flags
// Modports: master = producer/consumer side, slave = shifter side.
interface pipelined_shifter_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) ();
  localparam int AW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AW-1:0]    in_amt;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_carry;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_carry, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_carry, out_zero
  );
endinterface

// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - pipelined barrel shifter/rotator with tag sideband
// Purpose: log2(WIDTH) mux levels, LSB first, with a register stage after every
//   LEVELS_PER_STAGE levels; the last stage register drives the result port.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    pipelined_shifter_if.slave (in_* request, out_* result, flags)
// Ops: 000/010 SLL, 001 SRL, 011 SRA, 1x0 ROL, 1x1 ROR.
// Optional: define SHIFTER_FLAGS_EN for out_carry/out_zero; otherwise both tie to 0.
module pipelined_shifter #(
  parameter int WIDTH            = 32,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAG_W            = 5
) (
  input logic                clk,
  input logic                rst_n,
  pipelined_shifter_if.slave bus
);
  localparam int N = $clog2(WIDTH);
  localparam int S = (N + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  // Stage registers; index S-1 is the output register.
  logic             vld_q  [S];
  logic [WIDTH-1:0] data_q [S];
  logic [N-1:0]     amt_q  [S];
  logic [2:0]       op_q   [S];
  logic [TAG_W-1:0] tag_q  [S];
`ifdef SHIFTER_FLAGS_EN
  logic             carry_q [S];
  logic             zero_q;
`endif

  logic stall;
  logic advance;

  // The whole pipeline freezes only when the output holds an unconsumed result.
  assign stall        = vld_q[S-1] && !bus.out_ready;
  assign advance      = !stall;
  assign bus.in_ready = advance;

  // One mux level: shift/rotate by 2^k in the direction the op selects.
  function automatic logic [WIDTH-1:0] level_shift(input logic [WIDTH-1:0] d,
                                                    input logic [2:0]       op,
                                                    input int               k);
    int sh;
    sh = 1 << k;
    if (op[2]) begin
      if (op[0]) level_shift = (d >> sh) | (d << (WIDTH - sh));
      else       level_shift = (d << sh) | (d >> (WIDTH - sh));
    end else if (op[0]) begin
      // Sign fill only for 011; 001 is a plain logical right shift.
      if (op[1]) level_shift = $unsigned($signed(d) >>> sh);
      else       level_shift = d >> sh;
    end else begin
      level_shift = d << sh;
    end
  endfunction

`ifdef SHIFTER_FLAGS_EN
  function automatic logic bit_at(input logic [WIDTH-1:0] d, input int i);
    logic [WIDTH-1:0] t;
    t = d >> i;
    return t[0];
  endfunction
`endif

  for (genvar s = 0; s < S; s++) begin : g_stage
    localparam int LO = s * LEVELS_PER_STAGE;
    localparam int HI = ((s + 1) * LEVELS_PER_STAGE < N) ? (s + 1) * LEVELS_PER_STAGE : N;

    logic             v_in;
    logic [WIDTH-1:0] d_in;
    logic [N-1:0]     a_in;
    logic [2:0]       op_in;
    logic [TAG_W-1:0] tag_in;
    logic [WIDTH-1:0] data_d;
`ifdef SHIFTER_FLAGS_EN
    logic             c_in;
    logic             carry_d;
`endif

    if (s == 0) begin : g_src
      assign v_in   = bus.in_valid;
      assign d_in   = bus.in_data;
      assign a_in   = bus.in_amt;
      assign op_in  = bus.in_op;
      assign tag_in = bus.in_tag;
`ifdef SHIFTER_FLAGS_EN
      assign c_in   = 1'b0;
`endif
    end else begin : g_src
      assign v_in   = vld_q[s-1];
      assign d_in   = data_q[s-1];
      assign a_in   = amt_q[s-1];
      assign op_in  = op_q[s-1];
      assign tag_in = tag_q[s-1];
`ifdef SHIFTER_FLAGS_EN
      assign c_in   = carry_q[s-1];
`endif
    end

    // Levels run LSB first, so the last active level is the highest set amount
    // bit and the bit it pushes out is the overall last bit shifted out. For
    // rotates that same bit lands at result[0] (ROL) or result[WIDTH-1] (ROR).
    always_comb begin
      data_d = d_in;
`ifdef SHIFTER_FLAGS_EN
      carry_d = c_in;
`endif
      for (int k = LO; k < HI; k++) begin
        if (a_in[k]) begin
`ifdef SHIFTER_FLAGS_EN
          carry_d = op_in[0] ? bit_at(data_d, (1 << k) - 1)
                             : bit_at(data_d, WIDTH - (1 << k));
`endif
          data_d = level_shift(data_d, op_in, k);
        end
      end
    end

    // Valid always advances (bubbles included); payload only loads with a
    // valid op so the output keeps the last result between operations.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q[s]   <= 1'b0;
        data_q[s]  <= '0;
        amt_q[s]   <= '0;
        op_q[s]    <= '0;
        tag_q[s]   <= '0;
`ifdef SHIFTER_FLAGS_EN
        carry_q[s] <= 1'b0;
`endif
      end else if (advance) begin
        vld_q[s] <= v_in;
        if (v_in) begin
          data_q[s]  <= data_d;
          amt_q[s]   <= a_in;
          op_q[s]    <= op_in;
          tag_q[s]   <= tag_in;
`ifdef SHIFTER_FLAGS_EN
          carry_q[s] <= carry_d;
`endif
        end
      end
    end

`ifdef SHIFTER_FLAGS_EN
    if (s == S - 1) begin : g_last
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          zero_q <= 1'b0;
        end else if (advance && v_in) begin
          zero_q <= (data_d == '0);
        end
      end
    end
`endif
  end

  // Consumed amount bits and the output stage's op/amount are carried for
  // uniformity of the stage record but never read back.
  logic unused_bits;
  always_comb begin
    unused_bits = 1'b0;
    for (int s = 0; s < S; s++) begin
      unused_bits = unused_bits ^ (^amt_q[s]) ^ (^op_q[s]);
    end
  end

  assign bus.out_valid = vld_q[S-1];
  assign bus.out_data  = data_q[S-1];
  assign bus.out_tag   = tag_q[S-1];
`ifdef SHIFTER_FLAGS_EN
  assign bus.out_carry = carry_q[S-1];
  assign bus.out_zero  = zero_q;
`else
  assign bus.out_carry = 1'b0;
  assign bus.out_zero  = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_shifter.sv
// tb/tb_pipelined_shifter.sv - directed self-checking bench for pipelined_shifter
module tb_pipelined_shifter;
  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pipelined_shifter_if #(.WIDTH(32), .TAG_W(5)) b32 ();
  pipelined_shifter_if #(.WIDTH(8),  .TAG_W(5)) b8 ();
  pipelined_shifter_if #(.WIDTH(64), .TAG_W(5)) b64 ();

  pipelined_shifter #(.WIDTH(32), .LEVELS_PER_STAGE(2), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b32)
  );
  pipelined_shifter #(.WIDTH(8), .LEVELS_PER_STAGE(1), .TAG_W(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(b8)
  );
  pipelined_shifter #(.WIDTH(64), .LEVELS_PER_STAGE(3), .TAG_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(b64)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the 32-bit DUT and check latency, result, tag and flags.
  task automatic run_one(input string tag, input logic [2:0] op, input logic [4:0] amt,
                         input logic [31:0] d, input logic [4:0] t, input logic [31:0] exp,
                         input logic expc, input logic expz);
    int n;
    b32.in_valid = 1'b1;
    b32.in_op    = op;
    b32.in_amt   = amt;
    b32.in_data  = d;
    b32.in_tag   = t;
    tick();
    b32.in_valid = 1'b0;
    n = 1;
    while (!b32.out_valid && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, 3);
    check({tag, "_data"}, b32.out_data, exp);
    check({tag, "_tag"}, b32.out_tag, t);
`ifdef SHIFTER_FLAGS_EN
    check({tag, "_carry"}, b32.out_carry, expc);
    check({tag, "_zero"}, b32.out_zero, expz);
`else
    check({tag, "_carry"}, b32.out_carry, 1'b0);
    check({tag, "_zero"}, b32.out_zero, 1'b0);
`endif
    tick();
  endtask

  logic [31:0] bp_exp;
  int          sent;
  int          got;
  int          hold;
  int          seen;
  int          n;
  logic        first_seen;

  initial begin
    rst_n = 1'b0;
    b32.in_valid = 1'b0; b32.in_data = '0; b32.in_amt = '0; b32.in_op = '0; b32.in_tag = '0;
    b32.out_ready = 1'b1;
    b8.in_valid = 1'b0;  b8.in_data = '0;  b8.in_amt = '0;  b8.in_op = '0;  b8.in_tag = '0;
    b8.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.in_data = '0; b64.in_amt = '0; b64.in_op = '0; b64.in_tag = '0;
    b64.out_ready = 1'b1;

    // Reset then idle
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_out_valid", b32.out_valid, 1'b0);
    check("rst_in_ready", b32.in_ready, 1'b1);
    check("rst_out_data", b32.out_data, 32'h0);
    check("rst_out_tag", b32.out_tag, 5'd0);
    check("rst_out_carry", b32.out_carry, 1'b0);
    check("rst_out_zero", b32.out_zero, 1'b0);
    check("rst8_out_valid", b8.out_valid, 1'b0);
    check("rst64_out_valid", b64.out_valid, 1'b0);

    // SLL, SRL, SRA back to back, one result per cycle, in order
    b32.in_valid = 1'b1; b32.in_data = 32'h8000_00F1; b32.in_amt = 5'd4;
    b32.in_op = 3'b000; b32.in_tag = 5'd1;
    tick();
    check("b2b_early1", b32.out_valid, 1'b0);
    b32.in_op = 3'b001; b32.in_tag = 5'd2;
    tick();
    check("b2b_early2", b32.out_valid, 1'b0);
    b32.in_op = 3'b011; b32.in_tag = 5'd3;
    tick();
    b32.in_valid = 1'b0;
    check("b2b_sll_valid", b32.out_valid, 1'b1);
    check("b2b_sll_data", b32.out_data, 32'h0000_0F10);
    check("b2b_sll_tag", b32.out_tag, 5'd1);
    check("b2b_sll_carry", b32.out_carry, 1'b0);
    tick();
    check("b2b_srl_valid", b32.out_valid, 1'b1);
    check("b2b_srl_data", b32.out_data, 32'h0800_000F);
    check("b2b_srl_tag", b32.out_tag, 5'd2);
    check("b2b_srl_carry", b32.out_carry, 1'b0);
    tick();
    check("b2b_sra_valid", b32.out_valid, 1'b1);
    check("b2b_sra_data", b32.out_data, 32'hF800_000F);
    check("b2b_sra_tag", b32.out_tag, 5'd3);
    check("b2b_sra_carry", b32.out_carry, 1'b0);
    tick();
    check("b2b_drained", b32.out_valid, 1'b0);

    // Rotates, aliases and boundary amounts
    run_one("rol8", 3'b100, 5'd8, 32'h1234_5678, 5'd4, 32'h3456_7812, 1'b0, 1'b0);
    run_one("ror8", 3'b101, 5'd8, 32'h1234_5678, 5'd5, 32'h7812_3456, 1'b0, 1'b0);
    run_one("rol8_alias", 3'b110, 5'd8, 32'h1234_5678, 5'd6, 32'h3456_7812, 1'b0, 1'b0);
    run_one("ror8_alias", 3'b111, 5'd8, 32'h1234_5678, 5'd7, 32'h7812_3456, 1'b0, 1'b0);
    run_one("sll_alias", 3'b010, 5'd4, 32'h8000_00F1, 5'd8, 32'h0000_0F10, 1'b0, 1'b0);
    run_one("srl31", 3'b001, 5'd31, 32'h8000_0000, 5'd9, 32'h0000_0001, 1'b0, 1'b0);
    run_one("sra31", 3'b011, 5'd31, 32'h8000_0000, 5'd10, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_one("rol31", 3'b100, 5'd31, 32'h0000_0001, 5'd11, 32'h8000_0000, 1'b0, 1'b0);
    run_one("sll31", 3'b000, 5'd31, 32'h0000_0003, 5'd12, 32'h8000_0000, 1'b1, 1'b0);
    run_one("srl_zero", 3'b001, 5'd1, 32'h0000_0001, 5'd13, 32'h0000_0000, 1'b1, 1'b1);
    run_one("ror1", 3'b101, 5'd1, 32'h0000_0001, 5'd14, 32'h8000_0000, 1'b1, 1'b0);
    for (int o = 0; o < 8; o++) begin
      run_one($sformatf("amt0_op%0d", o), o[2:0], 5'd0, 32'h1234_5678, o[4:0],
              32'h1234_5678, 1'b0, 1'b0);
    end

    // Backpressure: 5 ops, consumer holds off 4 cycles after the first result
    sent = 0; got = 0; hold = 0; first_seen = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      b32.in_valid = (sent < 5);
      b32.in_data  = 32'h0000_0011;
      b32.in_amt   = sent[4:0];
      b32.in_op    = 3'b000;
      b32.in_tag   = 5'(10 + sent);
      if (b32.out_valid && !first_seen) begin
        first_seen = 1'b1;
        hold = 4;
      end
      b32.out_ready = (hold == 0);
      #1;
      bp_exp = 32'h0000_0011 << got;
      if (hold > 0) begin
        check("bp_in_ready_low", b32.in_ready, 1'b0);
        check("bp_data_stable", b32.out_data, bp_exp);
      end
      if (b32.out_valid) begin
        check($sformatf("bp_data%0d", got), b32.out_data, bp_exp);
        check($sformatf("bp_tag%0d", got), b32.out_tag, 5'(10 + got));
        if (b32.out_ready) got++;
      end
      if (b32.in_valid && b32.in_ready) sent++;
      if (hold > 0) hold--;
      tick();
    end
    b32.in_valid = 1'b0;
    b32.out_ready = 1'b1;
    check("bp_results", got, 5);
    tick();
    tick();
    check("bp_no_dup", b32.out_valid, 1'b0);

    // Reset mid-flight discards both in-flight ops
    b32.in_valid = 1'b1; b32.in_data = 32'h0000_00FF; b32.in_amt = 5'd1;
    b32.in_op = 3'b000; b32.in_tag = 5'd20;
    tick();
    b32.in_tag = 5'd21;
    tick();
    check("mid_not_yet", b32.out_valid, 1'b0);
    rst_n = 1'b0;
    b32.in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (b32.out_valid) seen++;
      tick();
    end
    check("mid_flushed", seen, 0);
    run_one("post_rst", 3'b001, 5'd4, 32'h0000_0F00, 5'd22, 32'h0000_00F0, 1'b0, 1'b0);

    // WIDTH=8, one level per stage: latency 3
    b8.in_valid = 1'b1; b8.in_data = 8'h80; b8.in_amt = 3'd7; b8.in_op = 3'b011; b8.in_tag = 5'd7;
    tick();
    b8.in_valid = 1'b0;
    n = 1;
    while (!b8.out_valid && n < 10) begin
      tick();
      n++;
    end
    check("w8_lat", n, 3);
    check("w8_sra_data", b8.out_data, 8'hFF);
    check("w8_sra_tag", b8.out_tag, 5'd7);
    check("w8_sra_carry", b8.out_carry, 1'b0);
    tick();

    // WIDTH=64, three levels per stage: latency 2
    b64.in_valid = 1'b1; b64.in_data = 64'h1; b64.in_amt = 6'd63; b64.in_op = 3'b000;
    b64.in_tag = 5'd30;
    tick();
    b64.in_valid = 1'b0;
    n = 1;
    while (!b64.out_valid && n < 10) begin
      tick();
      n++;
    end
    check("w64_lat", n, 2);
    check("w64_sll_data", b64.out_data, 64'h8000_0000_0000_0000);
    check("w64_sll_tag", b64.out_tag, 5'd30);
    check("w64_sll_carry", b64.out_carry, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
